moore_code_decoder: RTL and testbench
=====================================

Name: moore_code_decoder

Overview:
- Receiver-side companion to the team's 4-state Moore sequence generator (serial data_in in, 2-bit state code out).
- Observes the generator's 2-bit output code stream and recovers the serial input bit that caused each transition.
- Packs recovered bits into WORD_W-bit words.
- Flags codes that no legal generator transition can produce, and tracks generator resets (return to the S0 code).

Parameters:
- WORD_W, 8, recovered bits per output word (2..32).
- ERRCNT_W, 8, width of the saturating error counter (used only when the optional feature is compiled in).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- code_in  input  2  generator state code: 2'b01=S0, 2'b10=S1, 2'b11=S2, 2'b00=S3.
- code_valid  input  1  code_in sampled this cycle.
- bit_out  output  1  recovered input bit.
- bit_valid  output  1  one-cycle pulse, bit_out valid.
- word_out  output  WORD_W  last completed word; newest bit in LSB.
- word_valid  output  1  one-cycle pulse, word_out updated.
- restart  output  1  one-cycle pulse, S0 code seen while in TRACK.
- err  output  1  one-cycle pulse, illegal transition.
- locked  output  1  high while in TRACK.
- err_count  output  ERRCNT_W  saturating error count; present only with the optional feature.

Behaviour:
- Interface fixed: one clock, clk; reset_n is asynchronous and active-low.
- Reset: FSM=HUNT, prev_code=S0, partial word and bit count cleared.
- Reset values of outputs: bit_out=0, bit_valid=0, word_out=0, word_valid=0, restart=0, err=0, locked=0, err_count=0.
- Reset mid-word discards the partial word.
- Only cycles with code_valid=1 are evaluated. Other cycles hold all state, and all pulses are 0.
- All outputs are registered. Latency is 1 cycle from the qualifying code_valid sample to the bit_valid, word_valid, err or restart pulse.
- HUNT: wait for the S0 code, then go to SYNC. Other codes are ignored, with no error.
- SYNC (prev = S0): the next code must be S1, which moves the FSM to TRACK with no bit emitted.
  - Any other code: err pulse, FSM returns to HUNT.
- TRACK: each code is decoded against prev_code.
  - S1->S1: bit 0.
  - S1->S2: bit 1.
  - S2->S1: bit 0.
  - S2->S3: bit 1.
  - S3->S3: bit 0.
  - S3->S2: bit 1.
  - Any other code is an error, except the S0 code handled below.
- On each legal TRACK transition: bit_valid=1, and bit_out takes the decoded bit.
  - Shift: partial = {partial[WORD_W-2:0], bit}; count increments.
  - When count reaches WORD_W: word_out is loaded with the completed word, word_valid pulses in the same cycle as that bit's bit_valid, count returns to 0.
- S0 code in TRACK: restart pulse, partial word and count cleared, FSM goes to SYNC. No err, no bit emitted.
- Illegal in TRACK (S1->S3, S2->S2, S3->S1): err pulse, partial word and count cleared, FSM goes to HUNT. word_out holds its last value.
- prev_code updates on every valid sample, in every state.
- Simultaneous events are impossible: one code yields exactly one of {bit, restart, err, none}.

Optional Feature:
- Macro: MOORE_DEC_ERRCNT_EN.
- Defined: err_count port exists. It increments on each err pulse, saturates at all-ones, and clears only on reset.
- Undefined: the err_count port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package moore_code_pkg holds:
  - the 2-bit code constants S0..S3 (shared with the generator);
  - the decoder FSM state enum HUNT/SYNC/TRACK.
- Sub-module moore_bit_packer: serial-to-parallel shift plus count, with inputs bit/valid/clear and outputs word/word_valid.
- The FSM and transition decode stay in the top level.

Test Plan:
- Reset, then codes 01,10,11,00,11,10 all valid -> bits 1,1,1,0 on four bit_valid pulses; locked=1 from the cycle after the 2'b10 sample.
- WORD_W=8 with bits 1,0,1,1,0,0,1,0 decoded -> single word_valid with word_out=8'hB2, coincident with the 8th bit_valid.
- In TRACK, prev=10 then code 00 -> err=1, locked=0, partial cleared. Next 01 then 10 -> relock, with no second err.
- 3 bits into a word, code 01 -> restart=1, no err. A later full 8 bits produce a word containing only the post-restart bits.
- Gaps in code_valid between samples -> no pulses in gap cycles; decoded bits identical to the gapless run.
- With MOORE_DEC_ERRCNT_EN, ERRCNT_W=2: 5 illegal transitions -> err_count=3; assert reset_n low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/moore_code_pkg.sv
// ----------------------------------------------------------------------------
// moore_code_pkg
// Shared definitions for the 4-state Moore sequence generator and its decoder.
// - CODE_S0..CODE_S3 : 2-bit state codes as emitted by the generator.
// - decState_e       : decoder FSM states (HUNT, SYNC, TRACK).
// No ports; imported by moore_code_decoder and its testbench.
// ----------------------------------------------------------------------------
package moore_code_pkg;

    localparam logic [1:0] CODE_S0 = 2'b01;
    localparam logic [1:0] CODE_S1 = 2'b10;
    localparam logic [1:0] CODE_S2 = 2'b11;
    localparam logic [1:0] CODE_S3 = 2'b00;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2
    } decState_e;

endpackage

// File: rtl/moore_bit_packer.sv
// ----------------------------------------------------------------------------
// moore_bit_packer
// Serial-to-parallel packer: shifts recovered bits in MSB-first order (newest
// bit lands in the LSB) and publishes a word every WORD_W bits.
// Ports:
//   clk          : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   bit_i        : bit to shift in
//   valid_i      : bit_i is valid this cycle
//   clear_i      : discard the partial word and restart the count
//   word_o       : last completed word (holds until the next completion)
//   word_valid_o : one-cycle pulse when word_o is updated
// ----------------------------------------------------------------------------
module moore_bit_packer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              bit_i,
    input  logic              valid_i,
    input  logic              clear_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);

    localparam int              CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] partial_q, partial_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              wordValid_q, wordValid_d;

    // Next-state for the shift register and bit count. Clear has priority
    // over a new bit; the decoder never asserts both, but a clear must always
    // win so a stale partial word can never leak into the next word.
    always_comb begin
        partial_d   = partial_q;
        count_d     = count_q;
        word_d      = word_q;
        wordValid_d = 1'b0;
        if (clear_i) begin
            partial_d = '0;
            count_d   = '0;
        end else if (valid_i) begin
            if (count_q == LAST_IDX) begin
                word_d      = {partial_q[WORD_W-2:0], bit_i};
                wordValid_d = 1'b1;
                partial_d   = '0;
                count_d     = '0;
            end else begin
                partial_d = {partial_q[WORD_W-2:0], bit_i};
                count_d   = count_q + CNT_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            partial_q   <= '0;
            count_q     <= '0;
            word_q      <= '0;
            wordValid_q <= 1'b0;
        end else begin
            partial_q   <= partial_d;
            count_q     <= count_d;
            word_q      <= word_d;
            wordValid_q <= wordValid_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = wordValid_q;

endmodule

// File: rtl/moore_code_decoder.sv
// ----------------------------------------------------------------------------
// moore_code_decoder
// Watches the 2-bit state-code stream of the 4-state Moore generator and
// recovers the serial bit behind each transition, packing bits into words.
// Optional feature: define MOORE_DEC_ERRCNT_EN to add the saturating
// err_count output (width ERRCNT_W).
// Ports:
//   clk        : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   code_in    : generator code (01=S0, 10=S1, 11=S2, 00=S3)
//   code_valid : code_in is sampled this cycle
//   bit_out    : recovered bit (holds between pulses)
//   bit_valid  : one-cycle pulse, bit_out valid
//   word_out   : last completed WORD_W-bit word, newest bit in LSB
//   word_valid : one-cycle pulse, word_out updated
//   restart    : one-cycle pulse, S0 code seen while tracking
//   err        : one-cycle pulse, illegal transition
//   locked     : high while tracking
//   err_count  : saturating error count (MOORE_DEC_ERRCNT_EN only)
// ----------------------------------------------------------------------------
module moore_code_decoder
    import moore_code_pkg::*;
#(
    parameter int WORD_W   = 8
`ifdef MOORE_DEC_ERRCNT_EN
   ,parameter int ERRCNT_W = 8
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          code_in,
    input  logic                code_valid,
    output logic                bit_out,
    output logic                bit_valid,
    output logic [WORD_W-1:0]   word_out,
    output logic                word_valid,
    output logic                restart,
    output logic                err,
    output logic                locked
`ifdef MOORE_DEC_ERRCNT_EN
   ,output logic [ERRCNT_W-1:0] err_count
`endif
);

    decState_e  state_q, state_d;
    logic [1:0] prevCode_q, prevCode_d;
    logic       bitOut_q, bitOut_d;
    logic       bitValid_q, bitValid_d;
    logic       restart_q, restart_d;
    logic       err_q, err_d;
    logic       locked_q, locked_d;

    logic       transLegal;
    logic       transBit;
    logic       packValid;
    logic       packClear;

    // Map a (previous, current) code pair to the generator input bit that
    // produced it. Only the six transitions the generator can make while
    // running are legal; S0 is handled separately by the FSM.
    always_comb begin
        transLegal = 1'b0;
        transBit   = 1'b0;
        case ({prevCode_q, code_in})
            {CODE_S1, CODE_S1}: begin transLegal = 1'b1; transBit = 1'b0; end
            {CODE_S1, CODE_S2}: begin transLegal = 1'b1; transBit = 1'b1; end
            {CODE_S2, CODE_S1}: begin transLegal = 1'b1; transBit = 1'b0; end
            {CODE_S2, CODE_S3}: begin transLegal = 1'b1; transBit = 1'b1; end
            {CODE_S3, CODE_S3}: begin transLegal = 1'b1; transBit = 1'b0; end
            {CODE_S3, CODE_S2}: begin transLegal = 1'b1; transBit = 1'b1; end
            default:            begin transLegal = 1'b0; transBit = 1'b0; end
        endcase
    end

    // FSM next state and registered-output next values. Each valid code
    // produces exactly one of {bit, restart, err, nothing}; invalid cycles
    // hold everything and leave the pulses low.
    always_comb begin
        state_d    = state_q;
        prevCode_d = prevCode_q;
        bitOut_d   = bitOut_q;
        bitValid_d = 1'b0;
        restart_d  = 1'b0;
        err_d      = 1'b0;
        packValid  = 1'b0;
        packClear  = 1'b0;
        if (code_valid) begin
            prevCode_d = code_in;
            case (state_q)
                HUNT: begin
                    if (code_in == CODE_S0) begin
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (code_in == CODE_S1) begin
                        state_d = TRACK;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end
                end
                TRACK: begin
                    if (code_in == CODE_S0) begin
                        restart_d = 1'b1;
                        packClear = 1'b1;
                        state_d   = SYNC;
                    end else if (transLegal) begin
                        bitValid_d = 1'b1;
                        bitOut_d   = transBit;
                        packValid  = 1'b1;
                    end else begin
                        err_d     = 1'b1;
                        packClear = 1'b1;
                        state_d   = HUNT;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
        locked_d = (state_d == TRACK);
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= HUNT;
            prevCode_q <= CODE_S0;
            bitOut_q   <= 1'b0;
            bitValid_q <= 1'b0;
            restart_q  <= 1'b0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prevCode_q <= prevCode_d;
            bitOut_q   <= bitOut_d;
            bitValid_q <= bitValid_d;
            restart_q  <= restart_d;
            err_q      <= err_d;
            locked_q   <= locked_d;
        end
    end

    moore_bit_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .bit_i        (transBit),
        .valid_i      (packValid),
        .clear_i      (packClear),
        .word_o       (word_out),
        .word_valid_o (word_valid)
    );

    assign bit_out   = bitOut_q;
    assign bit_valid = bitValid_q;
    assign restart   = restart_q;
    assign err       = err_q;
    assign locked    = locked_q;

`ifdef MOORE_DEC_ERRCNT_EN
    logic [ERRCNT_W-1:0] errCount_q;

    // Saturating error counter; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            errCount_q <= '0;
        end else if (err_d && (errCount_q != '1)) begin
            errCount_q <= errCount_q + ERRCNT_W'(1);
        end
    end

    assign err_count = errCount_q;
`endif

endmodule

// File: tb/tb_moore_code_decoder.sv
// ----------------------------------------------------------------------------
// tb_moore_code_decoder
// Scoreboard bench for moore_code_decoder. The stimulus side drives codes and
// pushes expected pulses from a generator-inverse reference model; a monitor
// pops and compares whenever the DUT emits a pulse. Define
// MOORE_DEC_ERRCNT_EN to exercise err_count (ERRCNT_W = 2).
// ----------------------------------------------------------------------------
module tb_moore_code_decoder;
    import moore_code_pkg::*;

    localparam int WORD_W = 8;
`ifdef MOORE_DEC_ERRCNT_EN
    localparam int ERRCNT_W = 2;
    localparam int ERR_MAX  = (1 << ERRCNT_W) - 1;
`else
    localparam int ERR_MAX  = 255;
`endif

    localparam int KIND_BIT     = 0;
    localparam int KIND_RESTART = 1;
    localparam int KIND_ERR     = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        code_in = CODE_S0;
    logic              code_valid = 1'b0;
    logic              bit_out;
    logic              bit_valid;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              restart;
    logic              err;
    logic              locked;
`ifdef MOORE_DEC_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_count;
`endif

    moore_code_decoder #(
        .WORD_W   (WORD_W)
`ifdef MOORE_DEC_ERRCNT_EN
       ,.ERRCNT_W (ERRCNT_W)
`endif
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .code_in    (code_in),
        .code_valid (code_valid),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .restart    (restart),
        .err        (err),
        .locked     (locked)
`ifdef MOORE_DEC_ERRCNT_EN
       ,.err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int   kind;
        logic bitVal;
        logic wordValid;
        int   errCnt;
    } event_t;

    event_t expQ[$];
    logic   capBits[$];
    int     checks = 0;
    int     errors = 0;

    // Reference model: mode 0=hunting, 1=waiting for first S1, 2=tracking.
    int                modelMode;
    logic [1:0]        modelPrev;
    bit                modelBits[$];
    logic [WORD_W-1:0] modelWord;
    int                modelErrCnt;
    logic              modelLocked;
    logic [1:0]        genState;

    // Forward model of the generator: the code it moves to on input b.
    function automatic logic [1:0] genNext(input logic [1:0] s, input logic b);
        case (s)
            CODE_S1: return b ? CODE_S2 : CODE_S1;
            CODE_S2: return b ? CODE_S3 : CODE_S1;
            CODE_S3: return b ? CODE_S2 : CODE_S3;
            default: return CODE_S1;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        modelMode   = 0;
        modelPrev   = CODE_S0;
        modelBits.delete();
        modelWord   = '0;
        modelErrCnt = 0;
        modelLocked = 1'b0;
    endtask

    task automatic modelErr(inout event_t e);
        e.kind = KIND_ERR;
        if (modelErrCnt < ERR_MAX) modelErrCnt++;
        modelBits.delete();
        modelMode = 0;
    endtask

    // Decode by inverting the generator: find the input bit that takes the
    // previous code to the current one.
    task automatic modelStep(input logic [1:0] code);
        event_t e;
        bit     have = 0;
        bit     found = 0;
        logic   b = 1'b0;
        logic [WORD_W-1:0] w;
        e.kind = KIND_BIT; e.bitVal = 1'b0; e.wordValid = 1'b0; e.errCnt = 0;
        if (modelMode == 0) begin
            if (code == CODE_S0) modelMode = 1;
        end else if (modelMode == 1) begin
            if (code == CODE_S1) modelMode = 2;
            else begin modelErr(e); have = 1; end
        end else begin
            if (code == CODE_S0) begin
                e.kind = KIND_RESTART; have = 1;
                modelBits.delete();
                modelMode = 1;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (genNext(modelPrev, k[0]) == code) begin found = 1; b = k[0]; end
                end
                have = 1;
                if (found) begin
                    e.kind = KIND_BIT; e.bitVal = b;
                    modelBits.push_back(b);
                    if (modelBits.size() == WORD_W) begin
                        w = '0;
                        foreach (modelBits[k]) w = (w << 1) | WORD_W'(modelBits[k]);
                        modelWord = w;
                        e.wordValid = 1'b1;
                        modelBits.delete();
                    end
                end else begin
                    modelErr(e);
                end
            end
        end
        modelPrev   = code;
        modelLocked = (modelMode == 2);
        e.errCnt    = modelErrCnt;
        if (have) expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [1:0] code, input logic valid);
        @(negedge clk);
        code_in    = code;
        code_valid = valid;
        if (valid) modelStep(code);
    endtask

    task automatic sendCode(input logic [1:0] code);
        applyStimulus(code, 1'b1);
        genState = code;
    endtask

    task automatic sendBit(input logic b);
        sendCode(genNext(genState, b));
    endtask

    task automatic sendSync();
        sendCode(CODE_S0);
        sendCode(CODE_S1);
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) applyStimulus(2'($urandom_range(0, 3)), 1'b0);
    endtask

    // Let the last driven sample land, then stop driving.
    task automatic drain();
        @(posedge clk);
        #2;
        code_valid = 1'b0;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_bit_out", 32'(bit_out), 32'd0);
        checkOutput("rst_bit_valid", 32'(bit_valid), 32'd0);
        checkOutput("rst_word_out", 32'(word_out), 32'd0);
        checkOutput("rst_word_valid", 32'(word_valid), 32'd0);
        checkOutput("rst_restart", 32'(restart), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_locked", 32'(locked), 32'd0);
`ifdef MOORE_DEC_ERRCNT_EN
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
`endif
    endtask

    // Asserts reset between edges and checks outputs clear immediately.
    task automatic resetDut();
        @(posedge clk);
        #3;
        reset_n    = 1'b0;
        code_valid = 1'b0;
        #1;
        checkResetOutputs();
        expQ.delete();
        modelReset();
        genState = CODE_S0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: compares every DUT pulse against the scoreboard and tracks the
    // level outputs against the model every cycle.
    initial begin
        event_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n) begin
                if (bit_valid || restart || err) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL spurious_pulse: got bv=%0b rs=%0b er=%0b, expected none (t=%0t)",
                                 bit_valid, restart, err, $time);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("bit_valid", 32'(bit_valid), 32'(e.kind == KIND_BIT));
                        checkOutput("restart", 32'(restart), 32'(e.kind == KIND_RESTART));
                        checkOutput("err", 32'(err), 32'(e.kind == KIND_ERR));
                        if (e.kind == KIND_BIT) checkOutput("bit_out", 32'(bit_out), 32'(e.bitVal));
                        checkOutput("word_valid", 32'(word_valid), 32'(e.wordValid));
`ifdef MOORE_DEC_ERRCNT_EN
                        checkOutput("err_count", 32'(err_count), 32'(e.errCnt));
`endif
                    end
                end else begin
                    checkOutput("word_valid_idle", 32'(word_valid), 32'd0);
                end
                if (bit_valid) capBits.push_back(bit_out);
                checkOutput("locked", 32'(locked), 32'(modelLocked));
                checkOutput("word_out", 32'(word_out), 32'(modelWord));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [3:0]  t1Exp;
        logic [15:0] patt;
        logic        refBits[$];
        int          r;

        modelReset();
        genState = CODE_S0;

        // Basic decode: 01,10,11,00,11,10 gives bits 1,1,1,0.
        $display("[TB] basic decode");
        resetDut();
        capBits.delete();
        sendCode(2'b01); sendCode(2'b10); sendCode(2'b11);
        sendCode(2'b00); sendCode(2'b11); sendCode(2'b10);
        drain();
        t1Exp = 4'b1110;
        checkOutput("t1_bit_count", 32'(capBits.size()), 32'd4);
        for (int k = 0; k < 4 && k < capBits.size(); k++)
            checkOutput("t1_bit", 32'(capBits[k]), 32'(t1Exp[3-k]));

        // Full word 1,0,1,1,0,0,1,0 -> 8'hB2.
        $display("[TB] word assembly");
        resetDut();
        sendSync();
        sendBit(1); sendBit(0); sendBit(1); sendBit(1);
        sendBit(0); sendBit(0); sendBit(1); sendBit(0);
        drain();
        checkOutput("word_B2", 32'(word_out), 32'hB2);
        checkOutput("word_B2_valid", 32'(word_valid), 32'd1);

        // Illegal S1->S3 in TRACK, then relock.
        $display("[TB] error and relock");
        sendSync();
        sendCode(CODE_S3);
        drain();
        checkOutput("err_drops_lock", 32'(locked), 32'd0);
        checkOutput("err_holds_word", 32'(word_out), 32'hB2);
        sendSync();
        drain();
        checkOutput("relock", 32'(locked), 32'd1);
        checkOutput("relock_no_err", 32'(err), 32'd0);

        // Restart after 3 bits discards them.
        $display("[TB] restart mid-word");
        resetDut();
        sendSync();
        sendBit(1); sendBit(1); sendBit(1);
        sendSync();
        sendBit(0); sendBit(1); sendBit(1); sendBit(0);
        sendBit(1); sendBit(0); sendBit(0); sendBit(1);
        drain();
        checkOutput("word_after_restart", 32'(word_out), 32'h69);

        // Gaps in code_valid must not change decoded bits.
        $display("[TB] gap equivalence");
        patt = 16'($urandom);
        resetDut();
        capBits.delete();
        sendSync();
        for (int k = 0; k < 16; k++) sendBit(patt[k]);
        drain();
        refBits = capBits;
        resetDut();
        capBits.delete();
        sendCode(CODE_S0); gap(2); sendCode(CODE_S1);
        for (int k = 0; k < 16; k++) begin
            gap($urandom_range(0, 3));
            sendBit(patt[k]);
        end
        drain();
        checkOutput("gap_bit_count", 32'(capBits.size()), 32'(refBits.size()));
        for (int k = 0; k < refBits.size() && k < capBits.size(); k++)
            checkOutput("gap_bit", 32'(capBits[k]), 32'(refBits[k]));

        // Five illegal transitions saturate a 2-bit counter at 3.
        $display("[TB] error counting");
        resetDut();
        for (int k = 0; k < 5; k++) begin
            sendSync();
            sendCode(CODE_S3);
        end
        drain();
`ifdef MOORE_DEC_ERRCNT_EN
        checkOutput("err_count_sat", 32'(err_count), 32'd3);
`endif
        sendSync();
        sendBit(1); sendBit(0); sendBit(1);
        resetDut();

        // Randomized stream: legal steps, restarts, random codes, gaps, resets.
        $display("[TB] random stream");
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 15)       gap($urandom_range(1, 3));
            else if (r < 20)  sendCode(CODE_S0);
            else if (r < 26)  sendCode(2'($urandom_range(0, 3)));
            else if (r == 99) resetDut();
            else              sendBit(1'($urandom));
        end
        drain();
        gap(3);
        @(posedge clk);
        #2;
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
